// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module : lsu_pkg
// Brief  : Shared funct3 codes, FSM states, exception codes and request checks
//          for the load/store unit.
// Rev    : 1.0
// ============================================================================
package lsu_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_CAPTURE = 2'd2,
    S_RESP    = 2'd3
  } lsu_state_t;

  typedef enum logic [1:0] {
    EXC_NONE       = 2'b00,
    EXC_MISALIGNED = 2'b01,
    EXC_ILLEGAL    = 2'b10
  } lsu_exc_t;

  // Illegal funct3 takes priority over misalignment.
  function automatic lsu_exc_t lsu_check(input logic       is_store,
                                         input logic [2:0] funct3,
                                         input logic [1:0] addr_lo);
    logic     legal;
    lsu_exc_t exc;
    if (is_store) legal = (funct3 == SB) || (funct3 == SH) || (funct3 == SW);
    else          legal = (funct3 == LB) || (funct3 == LH) || (funct3 == LW) ||
                          (funct3 == LBU) || (funct3 == LHU);
    exc = EXC_NONE;
    if (!legal)                                      exc = EXC_ILLEGAL;
    else if (funct3[1:0] == 2'b01 && addr_lo[0])     exc = EXC_MISALIGNED;
    else if (funct3[1:0] == 2'b10 && addr_lo != 2'b00) exc = EXC_MISALIGNED;
    return exc;
  endfunction

endpackage : lsu_pkg
`default_nettype wire

// File: rtl/lsu_load_align.sv
`default_nettype none
// ============================================================================
// Module : lsu_load_align
// Brief  : Selects the addressed byte/halfword of a memory word and
//          sign- or zero-extends it to 32 bits.
// Rev    : 1.0
// ============================================================================
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'(word_i >> {addr_lo_i, 3'b000});
    half_sel = 16'(word_i >> {addr_lo_i[1], 4'b0000});
    case (funct3_i)
      LB:      result_o = {{24{byte_sel[7]}}, byte_sel};
      LH:      result_o = {{16{half_sel[15]}}, half_sel};
      LBU:     result_o = {24'd0, byte_sel};
      LHU:     result_o = {16'd0, half_sel};
      default: result_o = word_i;
    endcase
  end

endmodule : lsu_load_align
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module : load_store_unit
// Brief  : Single-outstanding load/store unit between execute and a
//          byte-enabled synchronous data memory.
// Rev    : 1.0
// ============================================================================
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [4:0]        req_rd,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_data,
  output logic [4:0]        resp_rd,
  output logic [1:0]        resp_exc,
  output logic [31:0]       data_addr,
  output logic [31:0]       data_write,
  output logic [3:0]        data_write_byte,
  output logic              data_read_valid,
  output logic              data_write_valid,
  input  logic [31:0]       data_read
);

  lsu_state_t  state_q, state_d;
  logic        is_store_q, is_store_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic [4:0]  resp_rd_q, resp_rd_d;
  logic [1:0]  resp_exc_q, resp_exc_d;
  logic [31:0] data_addr_q, data_addr_d;
  logic [31:0] data_write_q, data_write_d;
  logic [3:0]  data_be_q, data_be_d;
  logic        rd_strobe_q, rd_strobe_d;
  logic        wr_strobe_q, wr_strobe_d;

  lsu_exc_t          req_exc;
  logic [ADDR_W-1:0] aligned_addr;
  logic [31:0]       load_result;

  lsu_load_align u_align (
    .word_i    (data_read),
    .addr_lo_i (addr_lo_q),
    .funct3_i  (funct3_q),
    .result_o  (load_result)
  );

  assign req_exc      = lsu_check(req_is_store, req_funct3, req_addr[1:0]);
  assign aligned_addr = req_addr & ~ADDR_W'(3);

  always_comb begin
    state_d     = state_q;
    is_store_d  = is_store_q;
    funct3_d    = funct3_q;
    addr_lo_d   = addr_lo_q;
    resp_data_d = resp_data_q;
    resp_rd_d   = resp_rd_q;
    resp_exc_d  = resp_exc_q;
    data_addr_d = data_addr_q;
    data_write_d = data_write_q;
    data_be_d   = data_be_q;
    rd_strobe_d = 1'b0;
    wr_strobe_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          is_store_d  = req_is_store;
          funct3_d    = req_funct3;
          addr_lo_d   = req_addr[1:0];
          resp_data_d = 32'd0;
          resp_exc_d  = req_exc;
          if (req_exc != EXC_NONE) begin
            resp_rd_d = 5'd0;
            state_d   = S_RESP;
          end else begin
            resp_rd_d   = req_is_store ? 5'd0 : req_rd;
            data_addr_d = 32'(aligned_addr);
            state_d     = S_ACCESS;
            // Memory-side outputs are registered here so they appear in ACCESS.
            if (req_is_store) begin
              wr_strobe_d = 1'b1;
              case (req_funct3)
                SB: begin
                  data_be_d    = 4'b0001 << req_addr[1:0];
                  data_write_d = {4{req_wdata[7:0]}};
                end
                SH: begin
                  data_be_d    = 4'b0011 << req_addr[1:0];
                  data_write_d = {2{req_wdata[15:0]}};
                end
                default: begin
                  data_be_d    = 4'b1111;
                  data_write_d = req_wdata;
                end
              endcase
            end else begin
              rd_strobe_d = 1'b1;
              data_be_d   = 4'b0000;
            end
          end
        end
      end
      S_ACCESS:  state_d = is_store_q ? S_RESP : S_CAPTURE;
      S_CAPTURE: begin
        resp_data_d = load_result;
        state_d     = S_RESP;
      end
      S_RESP: if (resp_ready) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      is_store_q   <= 1'b0;
      funct3_q     <= 3'd0;
      addr_lo_q    <= 2'd0;
      resp_data_q  <= 32'd0;
      resp_rd_q    <= 5'd0;
      resp_exc_q   <= 2'd0;
      data_addr_q  <= 32'd0;
      data_write_q <= 32'd0;
      data_be_q    <= 4'd0;
      rd_strobe_q  <= 1'b0;
      wr_strobe_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      is_store_q   <= is_store_d;
      funct3_q     <= funct3_d;
      addr_lo_q    <= addr_lo_d;
      resp_data_q  <= resp_data_d;
      resp_rd_q    <= resp_rd_d;
      resp_exc_q   <= resp_exc_d;
      data_addr_q  <= data_addr_d;
      data_write_q <= data_write_d;
      data_be_q    <= data_be_d;
      rd_strobe_q  <= rd_strobe_d;
      wr_strobe_q  <= wr_strobe_d;
    end
  end

  assign req_ready        = (state_q == S_IDLE) && !reset;
  assign resp_valid       = (state_q == S_RESP);
  assign resp_data        = resp_data_q;
  assign resp_rd          = resp_rd_q;
  assign resp_exc         = resp_exc_q;
  assign data_addr        = data_addr_q;
  assign data_write       = data_write_q;
  assign data_write_byte  = data_be_q;
  assign data_read_valid  = rd_strobe_q;
  assign data_write_valid = wr_strobe_q;

endmodule : load_store_unit
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_load_store_unit
// Brief  : Self-checking bench: directed vector table, hand-written stall and
//          reset sequences, then random traffic against a byte-array model.
// Rev    : 1.0
// ============================================================================
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_is_store = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [4:0]  req_rd = 5'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic [1:0]  resp_exc;
  logic [31:0] data_addr;
  logic [31:0] data_write;
  logic [3:0]  data_write_byte;
  logic        data_read_valid;
  logic        data_write_valid;
  logic [31:0] data_read = 32'd0;

  int n_checks = 0;
  int n_errors = 0;

  load_store_unit #(.ADDR_W(32)) dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_is_store     (req_is_store),
    .req_funct3       (req_funct3),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .req_rd           (req_rd),
    .resp_valid       (resp_valid),
    .resp_ready       (resp_ready),
    .resp_data        (resp_data),
    .resp_rd          (resp_rd),
    .resp_exc         (resp_exc),
    .data_addr        (data_addr),
    .data_write       (data_write),
    .data_write_byte  (data_write_byte),
    .data_read_valid  (data_read_valid),
    .data_write_valid (data_write_valid),
    .data_read        (data_read)
  );

  always #5 clk = ~clk;

  // Synchronous byte-enabled memory, 256 bytes.
  logic [31:0] mem [0:63];
  always @(posedge clk) begin
    if (data_write_valid)
      for (int b = 0; b < 4; b++)
        if (data_write_byte[b]) mem[data_addr[7:2]][8*b +: 8] <= data_write[8*b +: 8];
    if (data_read_valid) data_read <= mem[data_addr[7:2]];
  end

  // Reference memory as plain bytes.
  logic [7:0] ref_mem [0:255];

  typedef struct {
    bit          st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [4:0]  rd;
    logic [1:0]  e_exc;
    logic [31:0] e_data;
    logic [3:0]  e_be;
    logic [31:0] e_dw;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  function automatic int size_of(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
  endfunction

  // Reference outcome computed from size/alignment rules and byte memory.
  task automatic model(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, output logic [1:0] exc,
                       output logic [31:0] data, output logic [3:0] be,
                       output logic [31:0] dw);
    int  sz;
    bit  legal;
    int  off;
    logic [31:0] v;
    legal = st ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    sz = size_of(f3);
    off = int'(addr % 4);
    exc = 2'b00; data = 32'd0; be = 4'd0; dw = 32'd0;
    if (!legal) exc = 2'b10;
    else if ((addr % sz) != 0) exc = 2'b01;
    else if (st) begin
      be = 4'((2 ** sz - 1) * (2 ** off));
      for (int l = 0; l < 4; l++) dw[8*l +: 8] = wd[8*(l % sz) +: 8];
    end else begin
      v = 32'd0;
      for (int i = 0; i < sz; i++) v = v + (32'(ref_mem[addr[7:0] + 8'(i)]) << (8 * i));
      if (!f3[2] && sz < 4 && v[8*sz-1]) v = v - (32'd1 << (8 * sz));
      data = v;
    end
  endtask

  task automatic ref_store(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] wd);
    for (int i = 0; i < size_of(f3); i++) ref_mem[addr[7:0] + 8'(i)] = wd[8*i +: 8];
  endtask

  task automatic run_op(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [4:0] rd,
                        input logic [1:0] e_exc, input logic [31:0] e_data,
                        input logic [3:0] e_be, input logic [31:0] e_dw);
    int lat;
    int exp_lat;
    bit strobe_bad;
    exp_lat = (e_exc != 2'b00) ? 1 : (st ? 2 : 3);
    @(negedge clk);
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3;
    req_addr = addr; req_wdata = wd; req_rd = rd; resp_ready = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_wdata = $urandom; req_addr = $urandom; req_rd = 5'($urandom);
    lat = 0; strobe_bad = 1'b0;
    for (int c = 1; c <= 8 && lat == 0; c++) begin
      @(negedge clk);
      if (c == 1 && e_exc == 2'b00) begin
        chk("read_strobe", {31'd0, data_read_valid}, {31'd0, !st});
        chk("write_strobe", {31'd0, data_write_valid}, {31'd0, st});
        chk("data_addr", data_addr, addr & ~32'd3);
        chk("byte_en", {28'd0, data_write_byte}, st ? {28'd0, e_be} : 32'd0);
        if (st) chk("data_write", data_write, e_dw);
      end else if (data_read_valid || data_write_valid) strobe_bad = 1'b1;
      if (resp_valid) begin
        lat = c;
        chk("resp_data", resp_data, e_data);
        chk("resp_rd", {27'd0, resp_rd}, (!st && e_exc == 2'b00) ? {27'd0, rd} : 32'd0);
        chk("resp_exc", {30'd0, resp_exc}, {30'd0, e_exc});
      end
    end
    chk("latency", lat, exp_lat);
    chk("stray_strobe", {31'd0, strobe_bad}, 32'd0);
    if (st && e_exc == 2'b00) ref_store(addr, f3, wd);
  endtask

  vec_t vecs [$];

  initial begin
    logic [1:0]  m_exc;
    logic [31:0] m_data, m_dw;
    logic [3:0]  m_be;
    int          lat;
    bit          st;
    logic [2:0]  f3;
    logic [31:0] addr, wd;

    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'd0;

    vecs.push_back('{1, 3'b010, 32'h08, 32'hDEADBEEF, 5'd1, 2'b00, 32'h0, 4'b1111, 32'hDEADBEEF});
    vecs.push_back('{0, 3'b010, 32'h08, 32'h0,        5'd5, 2'b00, 32'hDEADBEEF, 4'b0, 32'h0});
    vecs.push_back('{1, 3'b000, 32'h05, 32'h000000A5, 5'd2, 2'b00, 32'h0, 4'b0010, 32'hA5A5A5A5});
    vecs.push_back('{0, 3'b000, 32'h05, 32'h0,        5'd3, 2'b00, 32'hFFFFFFA5, 4'b0, 32'h0});
    vecs.push_back('{0, 3'b100, 32'h05, 32'h0,        5'd4, 2'b00, 32'h000000A5, 4'b0, 32'h0});
    vecs.push_back('{1, 3'b001, 32'h0E, 32'h00008001, 5'd6, 2'b00, 32'h0, 4'b1100, 32'h80018001});
    vecs.push_back('{0, 3'b001, 32'h0E, 32'h0,        5'd7, 2'b00, 32'hFFFF8001, 4'b0, 32'h0});
    vecs.push_back('{0, 3'b101, 32'h0E, 32'h0,        5'd8, 2'b00, 32'h00008001, 4'b0, 32'h0});
    vecs.push_back('{0, 3'b010, 32'h06, 32'h0,        5'd9, 2'b01, 32'h0, 4'b0, 32'h0});
    vecs.push_back('{1, 3'b001, 32'h03, 32'h1234,     5'd10, 2'b01, 32'h0, 4'b0, 32'h0});
    vecs.push_back('{0, 3'b011, 32'h08, 32'h0,        5'd11, 2'b10, 32'h0, 4'b0, 32'h0});
    vecs.push_back('{1, 3'b100, 32'h08, 32'h0,        5'd12, 2'b10, 32'h0, 4'b0, 32'h0});
    vecs.push_back('{0, 3'b000, 32'h0B, 32'h0,        5'd13, 2'b00, 32'hFFFFFFDE, 4'b0, 32'h0});
    vecs.push_back('{0, 3'b100, 32'h09, 32'h0,        5'd14, 2'b00, 32'h000000BE, 4'b0, 32'h0});
    vecs.push_back('{0, 3'b001, 32'h0A, 32'h0,        5'd15, 2'b00, 32'hFFFFDEAD, 4'b0, 32'h0});
    vecs.push_back('{0, 3'b101, 32'h08, 32'h0,        5'd16, 2'b00, 32'h0000BEEF, 4'b0, 32'h0});

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_strobes", {30'd0, data_read_valid, data_write_valid}, 32'd0);
    chk("rst_data_addr", data_addr, 32'd0);
    reset = 1'b0;
    #1;
    chk("rst_release_ready", {31'd0, req_ready}, 32'd1);

    foreach (vecs[i])
      run_op(vecs[i].st, vecs[i].f3, vecs[i].addr, vecs[i].wd, vecs[i].rd,
             vecs[i].e_exc, vecs[i].e_data, vecs[i].e_be, vecs[i].e_dw);

    // Response back-pressure: outputs hold, new requests are ignored.
    @(negedge clk);
    req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b010;
    req_addr = 32'h08; req_rd = 5'd7; resp_ready = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 0;
    for (int c = 1; c <= 8 && lat == 0; c++) begin
      @(negedge clk);
      if (resp_valid) lat = c;
    end
    chk("stall_latency", lat, 3);
    req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h10; req_wdata = 32'hFFFFFFFF; req_rd = 5'd0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_resp_valid", {31'd0, resp_valid}, 32'd1);
      chk("stall_resp_data", resp_data, 32'hDEADBEEF);
      chk("stall_resp_rd", {27'd0, resp_rd}, 32'd7);
      chk("stall_req_ready", {31'd0, req_ready}, 32'd0);
      chk("stall_no_write", {31'd0, data_write_valid}, 32'd0);
    end
    req_valid = 1'b0; resp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("stall_release_idle", {31'd0, req_ready}, 32'd1);
    run_op(0, 3'b010, 32'h10, 32'h0, 5'd3, 2'b00, 32'h0, 4'b0, 32'h0);

    // Reset in the middle of a store access.
    @(negedge clk);
    req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h20; req_wdata = 32'h12345678;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("pre_reset_strobe", {31'd0, data_write_valid}, 32'd1);
    reset = 1'b1;
    #1;
    chk("reset_strobe_drop", {31'd0, data_write_valid}, 32'd0);
    chk("reset_req_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset_release_ready", {31'd0, req_ready}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("reset_no_resp", {31'd0, resp_valid}, 32'd0);
    end
    run_op(0, 3'b010, 32'h20, 32'h0, 5'd4, 2'b00, 32'h0, 4'b0, 32'h0);

    // Random traffic against the byte-level model.
    for (int n = 0; n < 80; n++) begin
      st   = 1'($urandom);
      f3   = ($urandom_range(0, 7) == 0) ? 3'($urandom) :
             (st ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 2)) | ($urandom_range(0, 1) ? 3'b100 : 3'b000));
      addr = 32'($urandom_range(0, 255));
      wd   = $urandom;
      model(st, f3, addr, wd, m_exc, m_data, m_be, m_dw);
      run_op(st, f3, addr, wd, 5'($urandom_range(1, 31)), m_exc, m_data, m_be, m_dw);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_load_store_unit
`default_nettype wire
